// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: strobes bit_end_o on the last clk_t cycle of each serial bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk_t,
  input  logic srst,
  input  logic run_i,
  output logic bit_end_o,
  output logic bit_end_nxt_o
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end_o = run_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (bit_end_o || !run_i) begin
      cnt_d = '0;
    end
  end

  // Lets the FSM register outputs that must line up with the next cycle's bit_end.
  assign bit_end_nxt_o = (cnt_d == CntLast);

  always_ff @(posedge clk_t) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, LSB-first data, optional parity, stop; back-to-back capable.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk_t,
  input  logic       srst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end, bit_end_nxt;
  logic                 accept;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk_t        (clk_t),
    .srst         (srst),
    .run_i        (state_q != IDLE),
    .bit_end_o    (bit_end),
    .bit_end_nxt_o(bit_end_nxt)
  );

  // Ready in the last stop cycle so a queued byte follows with no idle gap.
  assign tx_ready = !srst && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = calc_parity(tx_data, PARITY_ODD);
          tx_d    = START_BIT;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = STOP_BIT;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (accept) begin
            state_d = START;
            shift_d = tx_data;
            par_d   = calc_parity(tx_data, PARITY_ODD);
            tx_d    = START_BIT;
          end else begin
            state_d = IDLE;
            tx_d    = STOP_BIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && bit_end_nxt;
  end

  always_ff @(posedge clk_t) begin
    if (srst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx over four parameterisations sharing one clock.
module tb_uart_tx;

  typedef struct packed {
    logic tx;
    logic done;
    logic busy;
    logic ready;
  } exp_t;

  localparam int unsigned CLKS [4] = '{1, 1, 1, 4};
  localparam bit          PEN  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit          PODD [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic       clk;
  logic [3:0] srst, valid, tx_w, busy_w, done_w, ready_w;
  logic [7:0] data [4];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut0 (
    .clk_t(clk), .srst(srst[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut1 (
    .clk_t(clk), .srst(srst[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut2 (
    .clk_t(clk), .srst(srst[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut3 (
    .clk_t(clk), .srst(srst[3]), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Expected per-cycle {tx, done, busy, ready} for one frame accepted on instance k.
  function automatic void push_frame(input int k, input logic [7:0] b);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PEN[k]) bits.push_back((^b) ^ PODD[k]);
    bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      for (int r = 0; r < int'(CLKS[k]); r++) begin
        e.tx    = bits[j];
        e.done  = (j == bits.size() - 1) && (r == int'(CLKS[k]) - 1);
        e.busy  = 1'b1;
        e.ready = e.done;
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== 4'b1000) begin
        n_errors++;
        $display("FAIL reset_state dut%0d {tx,done,busy,ready}: got %b want 1000", k,
                 {tx_w[k], done_w[k], busy_w[k], ready_w[k]});
      end
    end
    @(posedge clk); #1;
    srst = '0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== 4'b1001) begin
        n_errors++;
        $display("FAIL ready_after_reset dut%0d {tx,done,busy,ready}: got %b want 1001", k,
                 {tx_w[k], done_w[k], busy_w[k], ready_w[k]});
      end
    end
  endtask

  task automatic test_frame(input int k, input logic [7:0] b, input string nm,
                            output logic [63:0] cap);
    exp_t e;
    int   cyc;
    cap = '0;
    exp_q.delete();
    @(posedge clk); #1;
    data[k]  = b;
    valid[k] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ready_w[k] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", nm, ready_w[k]);
    end
    @(posedge clk);
    push_frame(k, b);
    #1;
    valid[k] = 1'b0;
    data[k]  = 8'($urandom);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      e   = exp_q.pop_front();
      cap = {cap[62:0], tx_w[k]};
      n_checks++;
      if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== e) begin
        n_errors++;
        $display("FAIL %s cycle %0d {tx,done,busy,ready}: got %b want %b", nm, cyc,
                 {tx_w[k], done_w[k], busy_w[k], ready_w[k]}, e);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== 4'b1001) begin
      n_errors++;
      $display("FAIL %s idle_after {tx,done,busy,ready}: got %b want 1001", nm,
               {tx_w[k], done_w[k], busy_w[k], ready_w[k]});
    end
  endtask

  task automatic test_frames();
    logic [63:0] cap;
    test_frame(0, 8'hA5, "a5_even", cap);
    n_checks++;
    if (cap[10:0] !== 11'b01010010101) begin
      n_errors++;
      $display("FAIL a5_even_line: got %b want 01010010101", cap[10:0]);
    end
    test_frame(0, 8'h01, "01_even", cap);
    n_checks++;
    if (cap[10:0] !== 11'b01000000011) begin
      n_errors++;
      $display("FAIL 01_even_line: got %b want 01000000011", cap[10:0]);
    end
    test_frame(1, 8'h01, "01_odd", cap);
    n_checks++;
    if (cap[10:0] !== 11'b01000000001) begin
      n_errors++;
      $display("FAIL 01_odd_line: got %b want 01000000001", cap[10:0]);
    end
    test_frame(2, 8'h01, "01_nopar", cap);
    n_checks++;
    if (cap[9:0] !== 10'b0100000001) begin
      n_errors++;
      $display("FAIL 01_nopar_line: got %b want 0100000001", cap[9:0]);
    end
    test_frame(3, 8'h3C, "3c_x4", cap);
    n_checks++;
    if (cap[43:0] !== {{12{1'b0}}, {16{1'b1}}, {12{1'b0}}, {4{1'b1}}}) begin
      n_errors++;
      $display("FAIL 3c_x4_line: got %h want %h", cap[43:0],
               {{12{1'b0}}, {16{1'b1}}, {12{1'b0}}, {4{1'b1}}});
    end
  endtask

  // tx_valid held high across three bytes; accepts land at the end of each frame.
  task automatic test_back_to_back(input int k);
    exp_t e;
    int   len;
    len = (PEN[k] ? 11 : 10) * int'(CLKS[k]);
    exp_q.delete();
    @(posedge clk); #1;
    data[k]  = 8'h00;
    valid[k] = 1'b1;
    @(posedge clk);
    push_frame(k, 8'h00);
    push_frame(k, 8'hFF);
    push_frame(k, 8'h5A);
    #1;
    data[k] = 8'hFF;
    for (int i = 1; i <= 3 * len; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== e) begin
        n_errors++;
        $display("FAIL b2b dut%0d cycle %0d {tx,done,busy,ready}: got %b want %b", k, i,
                 {tx_w[k], done_w[k], busy_w[k], ready_w[k]}, e);
      end
      @(posedge clk); #1;
      if (i == len) data[k] = 8'h5A;
      if (i == 2 * len) begin
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== 4'b1001) begin
      n_errors++;
      $display("FAIL b2b dut%0d idle_after {tx,done,busy,ready}: got %b want 1001", k,
               {tx_w[k], done_w[k], busy_w[k], ready_w[k]});
    end
  endtask

  task automatic test_abort();
    exp_t        e;
    logic [63:0] cap;
    exp_q.delete();
    @(posedge clk); #1;
    data[0]  = 8'hFF;
    valid[0] = 1'b1;
    @(posedge clk);
    push_frame(0, 8'hFF);
    #1;
    valid[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({tx_w[0], done_w[0], busy_w[0], ready_w[0]} !== e) begin
        n_errors++;
        $display("FAIL abort_pre cycle %0d {tx,done,busy,ready}: got %b want %b", c,
                 {tx_w[0], done_w[0], busy_w[0], ready_w[0]}, e);
      end
      @(posedge clk); #1;
      if (c == 4) srst[0] = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if ({tx_w[0], done_w[0], busy_w[0], ready_w[0]} !== 4'b1000) begin
      n_errors++;
      $display("FAIL abort_in_reset {tx,done,busy,ready}: got %b want 1000",
               {tx_w[0], done_w[0], busy_w[0], ready_w[0]});
    end
    @(posedge clk); #1;
    srst[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_w[0], done_w[0], busy_w[0], ready_w[0]} !== 4'b1001) begin
        n_errors++;
        $display("FAIL abort_after cycle %0d {tx,done,busy,ready}: got %b want 1001", c,
                 {tx_w[0], done_w[0], busy_w[0], ready_w[0]});
      end
    end
    exp_q.delete();
    test_frame(0, 8'h5A, "abort_next_5a", cap);
  endtask

  // Inputs scrambled every cycle after accept; valid kept low only in the ready cycle.
  task automatic test_data_change(input int k);
    exp_t e;
    int   cyc;
    exp_q.delete();
    @(posedge clk); #1;
    data[k]  = 8'h81;
    valid[k] = 1'b1;
    @(posedge clk);
    push_frame(k, 8'h81);
    #1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      data[k]  = 8'($urandom);
      valid[k] = exp_q[0].ready ? 1'b0 : 1'($urandom);
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      n_checks++;
      if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== e) begin
        n_errors++;
        $display("FAIL data_change dut%0d cycle %0d {tx,done,busy,ready}: got %b want %b", k,
                 cyc, {tx_w[k], done_w[k], busy_w[k], ready_w[k]}, e);
      end
      @(posedge clk); #1;
    end
    valid[k] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx_w[k], done_w[k], busy_w[k], ready_w[k]} !== 4'b1001) begin
      n_errors++;
      $display("FAIL data_change dut%0d idle_after {tx,done,busy,ready}: got %b want 1001", k,
               {tx_w[k], done_w[k], busy_w[k], ready_w[k]});
    end
  endtask

  initial begin
    clk   = 1'b0;
    srst  = '1;
    valid = '0;
    for (int k = 0; k < 4; k++) data[k] = 8'h00;
    test_reset();
    test_frames();
    test_back_to_back(0);
    test_back_to_back(2);
    test_abort();
    test_data_change(0);
    test_data_change(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
